signed_sub_arbiter: RTL and testbench



---
 rtl/signed_sub_arbiter.sv | 160 ++++++++++++++++
 tb/tb_signed_sub_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/signed_sub_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : signed_sub_arbiter
// Description : Round-robin arbiter and sequencer in front of one shared
//               signed subtractor. Up to N_REQ requesters each offer an
//               operand pair (a, b) with a valid/ready handshake. One request
//               is accepted at a time. Its operands are registered, and
//               diff = a - b is computed at WIDTH+1 bits so it cannot
//               overflow. The result is returned tagged with the index of the
//               requester that owns it. Only one operation is in flight.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1              rising-edge clock
//   rst_n        in   1              asynchronous active-low reset
//   i_req_valid  in   N_REQ          per-requester request valid
//   o_req_ready  out  N_REQ          one-hot grant/accept (combinational)
//   i_req_a      in   N_REQ*WIDTH    signed minuends, slot i at [i*WIDTH +: WIDTH]
//   i_req_b      in   N_REQ*WIDTH    signed subtrahends, same packing
//   o_resp_valid out  1              result valid (registered)
//   i_resp_ready in   1              consumer accepts result
//   o_resp_id    out  clog2(N_REQ)   owner of the result (registered)
//   o_resp_diff  out  WIDTH+1        signed a - b (registered)
//   o_busy       out  1              high whenever not idle
// ============================================================================
module signed_sub_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           i_req_valid,
  output logic [N_REQ-1:0]           o_req_ready,
  input  logic [N_REQ*WIDTH-1:0]     i_req_a,
  input  logic [N_REQ*WIDTH-1:0]     i_req_b,
  output logic                       o_resp_valid,
  input  logic                       i_resp_ready,
  output logic [$clog2(N_REQ)-1:0]   o_resp_id,
  output logic [WIDTH:0]             o_resp_diff,
  output logic                       o_busy
);

  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_HOLD = 2'b10
  } state_t;

  state_t                   r_state;
  logic [ID_W-1:0]          r_rr_ptr;
  logic [ID_W-1:0]          r_id_q;
  logic [WIDTH-1:0]         r_op_a;
  logic [WIDTH-1:0]         r_op_b;
  logic                     r_resp_valid;
  logic [ID_W-1:0]          r_resp_id;
  logic [WIDTH:0]           r_resp_diff;

  logic                     w_any;
  logic [ID_W-1:0]          w_gnt_idx;
  logic [ID_W-1:0]          w_ptr_next;
  logic [WIDTH-1:0]         w_gnt_a;
  logic [WIDTH-1:0]         w_gnt_b;
  logic [WIDTH:0]           w_diff;

  // Requester index at distance 'off' above 'base', wrapping modulo N_REQ.
  // N_REQ need not be a power of two, so the wrap is explicit.
  function automatic logic [ID_W-1:0] f_wrap(input logic [ID_W-1:0] base,
                                             input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  // Round-robin search from r_rr_ptr upward. The loop walks from the
  // farthest offset down to offset 0 so that the nearest valid requester
  // is the last one written and therefore wins.
  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req_valid[f_wrap(r_rr_ptr, k)]) begin
        w_any     = 1'b1;
        w_gnt_idx = f_wrap(r_rr_ptr, k);
      end
    end
  end

  assign w_gnt_a    = i_req_a[int'(w_gnt_idx)*WIDTH +: WIDTH];
  assign w_gnt_b    = i_req_b[int'(w_gnt_idx)*WIDTH +: WIDTH];
  assign w_ptr_next = (int'(w_gnt_idx) == N_REQ - 1) ? '0 : w_gnt_idx + 1'b1;

  // Sign-extend both operands by one bit before subtracting. The extra bit
  // covers the full range -(2^WIDTH - 1) .. +(2^WIDTH - 1) with no wrap.
  assign w_diff = {r_op_a[WIDTH-1], r_op_a} - {r_op_b[WIDTH-1], r_op_b};

  // The grant is combinational and is taken only in IDLE. It is gated with
  // rst_n so that no requester sees an accept while reset is held, even
  // though the state register already reads IDLE at that point. There is
  // deliberately no path from i_resp_ready.
  always_comb begin
    o_req_ready = '0;
    if (rst_n && (r_state == S_IDLE) && w_any) begin
      o_req_ready[w_gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_id_q       <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_diff  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // The handshake completes in this cycle, so capture at the edge.
          if (w_any) begin
            r_op_a   <= w_gnt_a;
            r_op_b   <= w_gnt_b;
            r_id_q   <= w_gnt_idx;
            r_rr_ptr <= w_ptr_next;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_resp_diff  <= w_diff;
          r_resp_id    <= r_id_q;
          r_resp_valid <= 1'b1;
          r_state      <= S_HOLD;
        end
        S_HOLD: begin
          // The result holds until it is consumed. After consumption,
          // diff and id keep their last values and only valid drops.
          if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign o_resp_valid = r_resp_valid;
  assign o_resp_id    = r_resp_id;
  assign o_resp_diff  = r_resp_diff;
  assign o_busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_signed_sub_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_signed_sub_arbiter
// Description : Self-checking bench for signed_sub_arbiter (N_REQ=4, WIDTH=4).
//               Expected grants come from a round-robin pointer model.
//               Expected differences come from plain integer arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signed_sub_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   i_req_valid = '0;
  logic [N-1:0]   o_req_ready;
  logic [N*W-1:0] i_req_a = '0;
  logic [N*W-1:0] i_req_b = '0;
  logic           o_resp_valid;
  logic           i_resp_ready = 1'b0;
  logic [1:0]     o_resp_id;
  logic [W:0]     o_resp_diff;
  logic           o_busy;

  int errors = 0;
  int checks = 0;
  int m_ptr  = 0;   // model of the round-robin pointer

  signed_sub_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_a      (i_req_a),
    .i_req_b      (i_req_b),
    .o_resp_valid (o_resp_valid),
    .i_resp_ready (i_resp_ready),
    .o_resp_id    (o_resp_id),
    .o_resp_diff  (o_resp_diff),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (obs=running exp=finished)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: the first valid index at or above ptr, wrapping.
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Run one complete transaction from an IDLE cycle to the IDLE cycle after
  // the response is consumed. The consumer stalls 'wt' cycles in HOLD.
  task automatic do_op(input logic [N-1:0] v, input logic [N*W-1:0] av,
                       input logic [N*W-1:0] bv, input int wt);
    int g;
    int ed;
    logic signed [W-1:0] ta;
    logic signed [W-1:0] tb;
    logic [31:0] edl;
    i_req_valid = v;
    i_req_a     = av;
    i_req_b     = bv;
    @(negedge clk);
    g = pick(v, m_ptr);
    chk("idle_busy", {31'b0, o_busy}, 32'd0);
    chk("grant", {28'b0, o_req_ready}, 32'(1 << g));
    ta  = av[g*W +: W];
    tb  = bv[g*W +: W];
    ed  = int'(ta) - int'(tb);
    edl = ed;
    @(posedge clk); #1;
    m_ptr = (g + 1) % N;
    i_resp_ready = (wt == 0);
    chk("calc_ready", {28'b0, o_req_ready}, 32'd0);
    chk("calc_no_valid", {31'b0, o_resp_valid}, 32'd0);
    chk("calc_busy", {31'b0, o_busy}, 32'd1);
    @(posedge clk); #1;
    chk("hold_valid", {31'b0, o_resp_valid}, 32'd1);
    chk("hold_diff", {27'b0, o_resp_diff}, {27'b0, edl[W:0]});
    chk("hold_id", {30'b0, o_resp_id}, 32'(g));
    for (int s = 0; s < wt; s++) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'b0, o_resp_valid}, 32'd1);
      chk("stall_diff", {27'b0, o_resp_diff}, {27'b0, edl[W:0]});
      chk("stall_id", {30'b0, o_resp_id}, 32'(g));
      chk("stall_ready", {28'b0, o_req_ready}, 32'd0);
      chk("stall_busy", {31'b0, o_busy}, 32'd1);
    end
    i_resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("done_valid", {31'b0, o_resp_valid}, 32'd0);
    chk("done_busy", {31'b0, o_busy}, 32'd0);
    chk("done_diff_kept", {27'b0, o_resp_diff}, {27'b0, edl[W:0]});
    chk("done_id_kept", {30'b0, o_resp_id}, 32'(g));
  endtask

  // A single requester 'idx' presenting (a, b). Other slots carry random data.
  task automatic do_single(input int idx, input int a, input int b, input int wt);
    logic [N*W-1:0] av;
    logic [N*W-1:0] bv;
    logic [N-1:0]   v;
    av = (N*W)'($urandom);
    bv = (N*W)'($urandom);
    av[idx*W +: W] = W'(a);
    bv[idx*W +: W] = W'(b);
    v = N'(1 << idx);
    do_op(v, av, bv, wt);
  endtask

  initial begin
    // Reset: all outputs are zero, even with requests present.
    i_req_valid = 4'b1111;
    #12;
    chk("rst_ready", {28'b0, o_req_ready}, 32'd0);
    chk("rst_valid", {31'b0, o_resp_valid}, 32'd0);
    chk("rst_id", {30'b0, o_resp_id}, 32'd0);
    chk("rst_diff", {27'b0, o_resp_diff}, 32'd0);
    chk("rst_busy", {31'b0, o_busy}, 32'd0);
    i_req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ptr = 0;

    // Single request from requester 0: 3 - 2 = 1.
    do_single(0, 3, 2, 0);

    // Signs and extremes on requester 2.
    do_single(2, -4, 1, 0);
    do_single(2, 7, -2, 1);
    do_single(2, -5, -3, 0);
    do_single(2, 6, 7, 0);
    do_single(2, -8, 7, 2);
    do_single(2, 7, -8, 0);

    // Pointer skip/wrap: the pointer is 3 and only requester 1 is valid.
    do_single(1, 1, 1, 0);
    // The pointer is now 2, so all-valid grants 2 and then 3 (pointer to 0).
    do_op(4'b1111, 16'($urandom), 16'($urandom), 0);
    do_op(4'b1111, 16'($urandom), 16'($urandom), 0);

    // Fairness: all valid from pointer 0 gives 0, 1, 2, 3, 0.
    for (int r = 0; r < 5; r++) begin
      do_op(4'b1111, 16'($urandom), 16'($urandom), 0);
    end

    // Backpressure: a stall of 5 in HOLD while requester 1 stays valid.
    do_single(1, -3, 4, 5);
    do_single(1, 5, 5, 0);

    // Reset during CALC with requester 3 granted.
    i_req_valid = 4'b1000;
    @(negedge clk);
    chk("mid_grant3", {28'b0, o_req_ready}, 32'b1000);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, o_resp_valid}, 32'd0);
    chk("mid_rst_busy", {31'b0, o_busy}, 32'd0);
    chk("mid_rst_ready", {28'b0, o_req_ready}, 32'd0);
    i_req_valid = '0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("mid_rst_no_resp", {31'b0, o_resp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    m_ptr = 0;
    do_op(4'b1010, 16'($urandom), 16'($urandom), 0);

    // Randomized traffic.
    for (int r = 0; r < 60; r++) begin
      do_op(4'($urandom_range(1, 15)), 16'($urandom), 16'($urandom),
            int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
